prio_event_encoder: RTL and testbench

PRIO_EVENT_ENCODER -- requirements
Module: prio_event_encoder

---
 rtl/prio_event_encoder.sv | 110 +++++++++++
 tb/tb_prio_event_encoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
// Sticky priority event encoder: latches request strobes and presents the highest
// eligible index over a valid/ready handshake. Optional macro PRIO_EVENT_ENCODER_MASK_EN adds mask_i.
module prio_event_encoder_cell (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic clr_i,
  output logic pend_o,
  output logic ovf_o
);
  logic pend_q, pend_d, ovf_q, ovf_d;

  // A request coinciding with the clear keeps the bit pending and is not a loss.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | req_i;
    ovf_d  = req_i & pend_q & ~clr_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;
endmodule

module prio_event_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
`ifdef PRIO_EVENT_ENCODER_MASK_EN
  input  logic [N-1:0] mask_i,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);
  logic [N-1:0] pend_w, ovf_w, clr_vec, elig_mask, eligible;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         hs, load;

`ifdef PRIO_EVENT_ENCODER_MASK_EN
  assign elig_mask = mask_i;
`else
  assign elig_mask = '1;
`endif

  assign hs   = out_valid_q & out_ready;
  assign load = ~out_valid_q | hs;

  always_comb begin
    clr_vec = '0;
    if (hs) clr_vec[out_idx_q] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_cell
      prio_event_encoder_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_i[g]),
        .clr_i (clr_vec[g]),
        .pend_o(pend_w[g]),
        .ovf_o (ovf_w[g])
      );
    end
  endgenerate

  // Selection sees only pre-edge pending, minus the index being served now.
  assign eligible = pend_w & ~clr_vec & elig_mask;

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = |eligible;
      out_idx_d   = '0;
      for (int i = 0; i < N; i++)
        if (eligible[i]) out_idx_d = W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pend_w;
  assign overflow  = |ovf_w;
endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder (N=8); mask scenario built with PRIO_EVENT_ENCODER_MASK_EN.
module tb_prio_event_encoder;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_i = '0;
  logic         out_valid, out_ready = 1'b0, overflow;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
`ifdef PRIO_EVENT_ENCODER_MASK_EN
  logic [N-1:0] mask_i = '1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prio_event_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
`ifdef PRIO_EVENT_ENCODER_MASK_EN
    .mask_i   (mask_i),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .pending  (pending),
    .overflow (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 8'hFF; out_ready = 1'b0;
    step();
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending got %h exp 00", pending); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    vectors++; if (out_idx !== 3'd0) begin miscompares++; $display("FAIL reset_idx got %0d exp 0", out_idx); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    rst = 1'b0; req_i = '0;
    step();
    vectors++; if ({out_valid, pending} !== 9'h000) begin miscompares++; $display("FAIL reset_release got %b/%h exp 0/00", out_valid, pending); end
  endtask

  task automatic test_priority_drain();
    logic [W-1:0] exp_idx [3];
    exp_idx = '{3'd7, 3'd5, 3'd2};
    out_ready = 1'b1; req_i = 8'b1010_0100;
    step();
    vectors++; if (pending !== 8'hA4 || out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_latch got %h/%b exp a4/0", pending, out_valid); end
    req_i = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin miscompares++; $display("FAIL drain_idx%0d got %b/%0d exp 1/%0d", i, out_valid, out_idx, exp_idx[i]); end
    end
    step();
    vectors++; if (out_valid !== 1'b0 || out_idx !== 3'd0 || pending !== 8'h00) begin miscompares++; $display("FAIL drain_empty got %b/%0d/%h exp 0/0/00", out_valid, out_idx, pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_no_preempt();
    out_ready = 1'b0; req_i = 8'h02;
    step();
    req_i = 8'h00;
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd1) begin miscompares++; $display("FAIL stall_first got %b/%0d exp 1/1", out_valid, out_idx); end
    req_i = 8'h40;
    step();
    req_i = 8'h00;
    vectors++; if (out_idx !== 3'd1 || pending !== 8'h42) begin miscompares++; $display("FAIL stall_hold got %0d/%h exp 1/42", out_idx, pending); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd1) begin miscompares++; $display("FAIL stall_hold2 got %b/%0d exp 1/1", out_valid, out_idx); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd6 || pending !== 8'h40) begin miscompares++; $display("FAIL stall_next got %b/%0d/%h exp 1/6/40", out_valid, out_idx, pending); end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL stall_empty got %b/%h exp 0/00", out_valid, pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0; req_i = 8'h08;
    step();
    req_i = 8'h00;
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_present got %b/%0d/%b exp 1/3/0", out_valid, out_idx, overflow); end
    req_i = 8'h08;
    step();
    req_i = 8'h00;
    vectors++; if (overflow !== 1'b1 || pending !== 8'h08) begin miscompares++; $display("FAIL ovf_pulse got %b/%h exp 1/08", overflow, pending); end
    step();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_one_cycle got %b exp 0", overflow); end
    out_ready = 1'b1; req_i = 8'h08;
    step();
    req_i = 8'h00;
    vectors++; if (pending !== 8'h08 || overflow !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL set_wins got %h/%b/%b exp 08/0/0", pending, overflow, out_valid); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd3) begin miscompares++; $display("FAIL set_wins_represent got %b/%0d exp 1/3", out_valid, out_idx); end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL ovf_empty got %b/%h exp 0/00", out_valid, pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; req_i = 8'h03;
    step();
    req_i = 8'h80;
    step();
    req_i = 8'h00;
    vectors++; if (out_idx !== 3'd1 || pending !== 8'h83) begin miscompares++; $display("FAIL b2b_first got %0d/%h exp 1/83", out_idx, pending); end
    step();
    vectors++; if (out_idx !== 3'd7 || pending !== 8'h81) begin miscompares++; $display("FAIL b2b_second got %0d/%h exp 7/81", out_idx, pending); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd0 || pending !== 8'h01) begin miscompares++; $display("FAIL b2b_third got %b/%0d/%h exp 1/0/01", out_valid, out_idx, pending); end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL b2b_empty got %b/%h exp 0/00", out_valid, pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; req_i = 8'h0F;
    step();
    req_i = 8'h00;
    step();
    vectors++; if (out_idx !== 3'd3 || pending !== 8'h0F) begin miscompares++; $display("FAIL mid_setup got %0d/%h exp 3/0f", out_idx, pending); end
    rst = 1'b1;
    step();
    vectors++; if ({out_valid, out_idx, overflow, pending} !== 13'h0) begin miscompares++; $display("FAIL mid_reset got %b/%0d/%b/%h exp 0/0/0/00", out_valid, out_idx, overflow, pending); end
    rst = 1'b0; req_i = 8'h01;
    step();
    req_i = 8'h00;
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h01) begin miscompares++; $display("FAIL mid_latch got %b/%h exp 0/01", out_valid, pending); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin miscompares++; $display("FAIL mid_present got %b/%0d exp 1/0", out_valid, out_idx); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL mid_empty got %b/%h exp 0/00", out_valid, pending); end
  endtask

`ifdef PRIO_EVENT_ENCODER_MASK_EN
  task automatic test_mask();
    logic [W-1:0] exp_idx [4];
    exp_idx = '{3'd7, 3'd6, 3'd5, 3'd4};
    mask_i = 8'h0F; out_ready = 1'b1; req_i = 8'hF1;
    step();
    req_i = 8'h00;
    step();
    vectors++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin miscompares++; $display("FAIL mask_first got %b/%0d exp 1/0", out_valid, out_idx); end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'hF0) begin miscompares++; $display("FAIL mask_block got %b/%h exp 0/f0", out_valid, pending); end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'hF0) begin miscompares++; $display("FAIL mask_hold got %b/%h exp 0/f0", out_valid, pending); end
    mask_i = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_idx !== exp_idx[i]) begin miscompares++; $display("FAIL mask_drain%0d got %b/%0d exp 1/%0d", i, out_valid, out_idx, exp_idx[i]); end
    end
    step();
    vectors++; if (out_valid !== 1'b0 || pending !== 8'h00) begin miscompares++; $display("FAIL mask_empty got %b/%h exp 0/00", out_valid, pending); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_priority_drain();
    test_stall_no_preempt();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef PRIO_EVENT_ENCODER_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
